nv_ram_rwsthp_60x168_fifo_ctrl: RTL and testbench
=================================================

Name: nv_ram_rwsthp_60x168_fifo_ctrl

Overview:
- Initiator/controller for a 60x168 two-port RAM that has a registered read address (re), a registered output stage (ore) and an output bypass mux.
- Presents a valid/ready push interface and a valid/ready pop interface; drives all RAM write and read ports.
- Absorbs the RAM's two-stage read latency with an internal output buffer, so pop-side backpressure never loses data.
- Used wherever a 168-bit, 60-deep flow-controlled FIFO is built on this RAM.

Parameters:
- DEPTH, 60, RAM entries; pointers wrap DEPTH-1 -> 0.
- WIDTH, 168, payload width.
- AW, 6, RAM address width.
- OBUF_DEPTH, 4, output buffer entries; must be >= 4.

Ports:
- clk  input  1  single clock for all logic.
- reset_  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_pvld  input  1  push valid.
- wr_prdy  output  1  push ready; equals (ram_cnt != DEPTH).
- wr_pd  input  WIDTH  push payload.
- rd_pvld  output  1  pop valid; equals (obuf_cnt != 0).
- rd_prdy  input  1  pop ready.
- rd_pd  output  WIDTH  pop payload; the obuf head entry.
- ram_we  output  1  RAM write enable; equals wr_pvld & wr_prdy.
- ram_wa  output  AW  RAM write address; equals wr_ptr.
- ram_di  output  WIDTH  RAM write data; equals wr_pd.
- ram_re  output  1  RAM read-address capture enable.
- ram_ra  output  AW  RAM read address; equals rd_ptr.
- ram_ore  output  1  RAM output-register enable.
- ram_byp_sel  output  1  tied 0.
- ram_dbyp  output  WIDTH  tied 0.
- ram_dout  input  WIDTH  RAM registered read data.

Behaviour:
- State:
  - wr_ptr, rd_ptr: mod DEPTH.
  - ram_cnt: 0..60, entries written and not yet issued for read.
  - s1_vld: re was issued last cycle.
  - s2_vld: ore was issued last cycle, so ram_dout is valid this cycle.
  - obuf: OBUF_DEPTH-entry flop FIFO with obuf_cnt.
- Reset (reset_ = 0 at a clk edge): wr_ptr, rd_ptr, ram_cnt, s1_vld, s2_vld and obuf_cnt all go to 0.
  - Consequently wr_prdy = 1, rd_pvld = 0, ram_we = 0, ram_re = 0, ram_ore = 0.
  - The rd_pd value after reset is don't-care.
  - Reset mid-operation discards all stored and in-flight data; in-flight reads are not completed.
- Push: on a cycle with ram_we = 1, wr_ptr increments (59 wraps to 0).
- Read issue: ram_re = (ram_cnt != 0) & (s1_vld + s2_vld + obuf_cnt < OBUF_DEPTH).
  - When ram_re = 1, rd_ptr increments with wrap.
- ram_cnt update:
  - Counts a push as +1 and a read issue as -1.
  - A simultaneous push and issue leaves ram_cnt unchanged.
  - The issue decision uses the registered ram_cnt, so an entry pushed in cycle t is issuable at the earliest in t+1.
- Pipeline:
  - s1_vld <= ram_re.
  - ram_ore = s1_vld.
  - s2_vld <= ram_ore.
  - When s2_vld = 1, ram_dout is pushed into obuf at the end of that cycle.
  - Credit accounting guarantees obuf never overflows; this is asserted.
- Pop: on rd_pvld & rd_prdy, the obuf head is dropped at the end of the cycle.
  - A simultaneous obuf push and pop leaves obuf_cnt unchanged.
- Latency on an empty FIFO:
  - Push accepted in cycle t -> re in t+1 -> ore in t+2 -> ram_dout valid in t+3 -> rd_pvld = 1 in t+4.
- Throughput: with rd_prdy held at 1, one entry per cycle sustained.
- Full: when ram_cnt = 60, wr_prdy = 0.
  - Total storage is 64 entries: 60 in the RAM plus OBUF_DEPTH in the output buffer.
- Order is strict FIFO across the RAM/obuf boundary and across pointer wrap.
- wr_pd is passed to ram_di combinationally; the upstream holds it stable while wr_pvld = 1.

Test Plan:
- Latency check: reset, push a single 168'hA5..A5 at cycle 10 with rd_prdy = 1.
  - Expect ram_re at 11, ram_ore at 12, and rd_pvld = 1 with rd_pd = A5..A5 at 14.
  - rd_pvld returns to 0 at 15.
- Fill to full: hold rd_prdy = 0, push incrementing values 0..70.
  - Expect 64 pushes accepted and wr_prdy = 0 afterward, with ram_cnt = 60 and obuf_cnt = 4.
  - Then pop all 64 and expect values 0..63 in order.
- Wrap-around: stream 200 incrementing words with wr_pvld = 1 and rd_prdy = 1.
  - Expect 200 in-order pops and wr_ptr/rd_ptr wrapping 59 -> 0 three times with no gaps after the initial fill.
- Random backpressure: randomize wr_pvld and rd_prdy at 50% for 5000 cycles.
  - Scoreboard must match, and obuf must never overflow.
- Reset mid-operation: with 30 entries stored and reads in flight, assert reset_ = 0 for 1 cycle.
  - Next cycle: rd_pvld = 0, wr_prdy = 1, ram_re = 0, ram_ore = 0.
  - A new push of 168'h1 pops as 168'h1 with 4-cycle latency.
- Simultaneous push and issue with ram_cnt = 1 and a push in the same cycle.
  - Expect ram_cnt to stay 1 and the issued address to be the older entry.

Source files
------------

// File: rtl/nv_ram_rwsthp_60x168_fifo_ctrl.sv
// FIFO controller for the 60x168 two-port RAM with registered read address
// (re) and registered output stage (ore). A small flop buffer behind the RAM
// absorbs the two-cycle read latency so pop backpressure never drops data.
module nv_ram_rwsthp_60x168_fifo_ctrl #(
   parameter int DEPTH      = 60,
   parameter int WIDTH      = 168,
   parameter int AW         = 6,
   parameter int OBUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic             ram_we,
   output logic [AW-1:0]    ram_wa,
   output logic [WIDTH-1:0] ram_di,
   output logic             ram_re,
   output logic [AW-1:0]    ram_ra,
   output logic             ram_ore,
   output logic             ram_byp_sel,
   output logic [WIDTH-1:0] ram_dbyp,
   input  logic [WIDTH-1:0] ram_dout
);

   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int OCW  = $clog2(OBUF_DEPTH + 1);
   localparam int OPW  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

   localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);
   localparam logic [AW-1:0]   PTR_LAST  = AW'(DEPTH - 1);
   localparam logic [OCW:0]    CREDITS   = (OCW + 1)'(OBUF_DEPTH);
   localparam logic [OCW-1:0]  OBUF_FULL = OCW'(OBUF_DEPTH);
   localparam logic [OPW-1:0]  OPTR_LAST = OPW'(OBUF_DEPTH - 1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNTW-1:0]  ram_cnt;
   logic             s1_vld;
   logic             s2_vld;
   logic [WIDTH-1:0] obuf [OBUF_DEPTH];
   logic [OPW-1:0]   obuf_wp;
   logic [OPW-1:0]   obuf_rp;
   logic [OCW-1:0]   obuf_cnt;
   logic [OCW:0]     credit_used;
   logic             obuf_pop;

   // Reads in flight (s1/s2) plus buffered entries must leave room for the
   // word being issued, so an issued read always has a landing slot.
   assign credit_used = (OCW + 1)'(s1_vld) + (OCW + 1)'(s2_vld) + {1'b0, obuf_cnt};

   assign wr_prdy     = (ram_cnt != CNT_FULL);
   assign ram_we      = wr_pvld & wr_prdy;
   assign ram_wa      = wr_ptr;
   assign ram_di      = wr_pd;
   assign ram_re      = (ram_cnt != '0) & (credit_used < CREDITS);
   assign ram_ra      = rd_ptr;
   assign ram_ore     = s1_vld;
   assign ram_byp_sel = 1'b0;
   assign ram_dbyp    = '0;
   assign rd_pvld     = (obuf_cnt != '0);
   assign rd_pd       = obuf[obuf_rp];
   assign obuf_pop    = rd_pvld & rd_prdy;

   // RAM write/read pointers and count of written-but-unissued entries
   always_ff @(posedge clk) begin
      if (!reset_) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
      end else begin
         if (ram_we) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
         end
         if (ram_re) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
         end
         if (ram_we && !ram_re) begin
            ram_cnt <= ram_cnt + CNTW'(1);
         end else if (!ram_we && ram_re) begin
            ram_cnt <= ram_cnt - CNTW'(1);
         end
      end
   end

   // Read pipeline: re -> ore -> ram_dout valid
   always_ff @(posedge clk) begin
      if (!reset_) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end else begin
         s1_vld <= ram_re;
         s2_vld <= ram_ore;
      end
   end

   // Output buffer pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset_) begin
         obuf_wp  <= '0;
         obuf_rp  <= '0;
         obuf_cnt <= '0;
      end else begin
         if (s2_vld) begin
            obuf_wp <= (obuf_wp == OPTR_LAST) ? '0 : obuf_wp + OPW'(1);
         end
         if (obuf_pop) begin
            obuf_rp <= (obuf_rp == OPTR_LAST) ? '0 : obuf_rp + OPW'(1);
         end
         if (s2_vld && !obuf_pop) begin
            obuf_cnt <= obuf_cnt + OCW'(1);
         end else if (!s2_vld && obuf_pop) begin
            obuf_cnt <= obuf_cnt - OCW'(1);
         end
      end
   end

   // Output buffer storage; payload needs no reset
   always_ff @(posedge clk) begin
      if (s2_vld) begin
         obuf[obuf_wp] <= ram_dout;
      end
   end

   // Credit accounting must keep the output buffer from overflowing
   a_obuf_no_overflow : assert property (@(posedge clk) disable iff (!reset_)
      (s2_vld && !obuf_pop) |-> (obuf_cnt != OBUF_FULL));

endmodule

// File: tb/tb_nv_ram_rwsthp_60x168_fifo_ctrl.sv
// Bench for nv_ram_rwsthp_60x168_fifo_ctrl: a behavioural RAM, a count-based
// occupancy/latency model with a data queue checked every cycle, and directed
// scenarios with literal expectations.
module tb_nv_ram_rwsthp_60x168_fifo_ctrl;

   localparam int DEPTH      = 60;
   localparam int WIDTH      = 168;
   localparam int AW         = 6;
   localparam int OBUF_DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_ = 1'b0;
   logic             wr_pvld = 1'b0;
   logic             wr_prdy;
   logic [WIDTH-1:0] wr_pd = '0;
   logic             rd_pvld;
   logic             rd_prdy = 1'b0;
   logic [WIDTH-1:0] rd_pd;
   logic             ram_we;
   logic [AW-1:0]    ram_wa;
   logic [WIDTH-1:0] ram_di;
   logic             ram_re;
   logic [AW-1:0]    ram_ra;
   logic             ram_ore;
   logic             ram_byp_sel;
   logic [WIDTH-1:0] ram_dbyp;
   logic [WIDTH-1:0] ram_dout;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   nv_ram_rwsthp_60x168_fifo_ctrl #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .AW(AW),
      .OBUF_DEPTH(OBUF_DEPTH)
   ) dut (
      .clk(clk),
      .reset_(reset_),
      .wr_pvld(wr_pvld),
      .wr_prdy(wr_prdy),
      .wr_pd(wr_pd),
      .rd_pvld(rd_pvld),
      .rd_prdy(rd_prdy),
      .rd_pd(rd_pd),
      .ram_we(ram_we),
      .ram_wa(ram_wa),
      .ram_di(ram_di),
      .ram_re(ram_re),
      .ram_ra(ram_ra),
      .ram_ore(ram_ore),
      .ram_byp_sel(ram_byp_sel),
      .ram_dbyp(ram_dbyp),
      .ram_dout(ram_dout)
   );

   // Behavioural two-port RAM: registered read address, registered output
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ra_q;
   logic [WIDTH-1:0] dout_q;
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ra_q <= ram_ra;
      if (ram_ore) dout_q <= mem[ra_q];
   end
   assign ram_dout = dout_q;

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: counts of pushes, issues and pops plus a data queue.
   // Entries issued and not popped occupy the read pipeline or the buffer;
   // an issue made in cycle c is poppable from cycle c+3.
   logic [WIDTH-1:0] q [$];
   int unsigned m_push, m_issue, m_pop, m_arr;
   logic h1, h2;

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      logic exp_wr_prdy, exp_re, exp_rd_pvld, exp_we;
      logic [WIDTH-1:0] dropped;
      if (!reset_) begin
         q.delete();
         m_push = 0; m_issue = 0; m_pop = 0; m_arr = 0;
         h1 = 1'b0; h2 = 1'b0;
      end else begin
         exp_wr_prdy = ((m_push - m_issue) != DEPTH);
         exp_re      = (m_push != m_issue) && ((m_issue - m_pop) < OBUF_DEPTH);
         exp_rd_pvld = (m_arr != m_pop);
         exp_we      = wr_pvld && exp_wr_prdy;
         chk("m_wr_prdy", WIDTH'(wr_prdy), WIDTH'(exp_wr_prdy));
         chk("m_ram_we", WIDTH'(ram_we), WIDTH'(exp_we));
         chk("m_ram_wa", WIDTH'(ram_wa), WIDTH'(m_push % DEPTH));
         chk("m_ram_di", ram_di, wr_pd);
         chk("m_ram_re", WIDTH'(ram_re), WIDTH'(exp_re));
         chk("m_ram_ra", WIDTH'(ram_ra), WIDTH'(m_issue % DEPTH));
         chk("m_ram_ore", WIDTH'(ram_ore), WIDTH'(h1));
         chk("m_rd_pvld", WIDTH'(rd_pvld), WIDTH'(exp_rd_pvld));
         chk("m_byp_sel", WIDTH'(ram_byp_sel), '0);
         chk("m_dbyp", ram_dbyp, '0);
         if (exp_rd_pvld && q.size() != 0) chk("m_rd_pd", rd_pd, q[0]);
         if (exp_we) begin
            q.push_back(wr_pd);
            m_push++;
         end
         if (exp_re) m_issue++;
         if (exp_rd_pvld && rd_prdy && q.size() != 0) begin
            dropped = q.pop_front();
            m_pop++;
         end
         if (h2) m_arr++;
         h2 = h1;
         h1 = exp_re;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_  = 1'b0;
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      wr_pd   = '0;
      repeat (2) next_cycle();
      reset_ = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < 6; i++) w = (w << 32) | WIDTH'($urandom);
      return w;
   endfunction

   // Single push into an empty FIFO; pins re/ore/rd_pvld timing literally
   task automatic latency_test(input logic [WIDTH-1:0] val, input string tag);
      int re_at = -1;
      int ore_at = -1;
      int pv_at = -1;
      logic [WIDTH-1:0] pd_seen = '0;
      logic pv5 = 1'b1;
      rd_prdy = 1'b1;
      wr_pvld = 1'b1;
      wr_pd   = val;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k == 0) chk({tag, "_accept"}, WIDTH'(ram_we), WIDTH'(1));
         if (ram_re && re_at < 0) re_at = k;
         if (ram_ore && ore_at < 0) ore_at = k;
         if (rd_pvld && pv_at < 0) begin
            pv_at = k;
            pd_seen = rd_pd;
         end
         if (k == 5) pv5 = rd_pvld;
         next_cycle();
         if (k == 0) begin
            wr_pvld = 1'b0;
            wr_pd   = '0;
         end
      end
      chk({tag, "_re_cycle"}, WIDTH'(re_at), WIDTH'(1));
      chk({tag, "_ore_cycle"}, WIDTH'(ore_at), WIDTH'(2));
      chk({tag, "_pvld_cycle"}, WIDTH'(pv_at), WIDTH'(4));
      chk({tag, "_pd"}, pd_seen, val);
      chk({tag, "_pvld_drop"}, WIDTH'(pv5), WIDTH'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] a5;
      logic hold;
      int v, acc, popped, pushed, first, last, rd_wraps, wr_wraps;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset_wr_prdy", WIDTH'(wr_prdy), WIDTH'(1));
      chk("reset_rd_pvld", WIDTH'(rd_pvld), WIDTH'(0));
      chk("reset_ram_we", WIDTH'(ram_we), WIDTH'(0));
      chk("reset_ram_re", WIDTH'(ram_re), WIDTH'(0));
      chk("reset_ram_ore", WIDTH'(ram_ore), WIDTH'(0));
      next_cycle();
      repeat (6) next_cycle();

      // Latency
      a5 = {21{8'hA5}};
      latency_test(a5, "lat");

      // Fill to full with no pops, then drain in order
      do_reset();
      rd_prdy = 1'b0;
      v = 0;
      acc = 0;
      for (int k = 0; k < 90; k++) begin
         wr_pvld = (v <= 70);
         wr_pd   = WIDTH'(v);
         @(negedge clk);
         if (wr_pvld && wr_prdy) begin
            acc++;
            v++;
         end
         next_cycle();
      end
      @(negedge clk);
      chk("fill_accepted", WIDTH'(acc), WIDTH'(64));
      chk("fill_wr_prdy", WIDTH'(wr_prdy), WIDTH'(0));
      chk("fill_rd_pvld", WIDTH'(rd_pvld), WIDTH'(1));
      next_cycle();
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      popped = 0;
      for (int k = 0; k < 200 && popped < 64; k++) begin
         @(negedge clk);
         if (rd_pvld) begin
            chk("fill_pop_data", rd_pd, WIDTH'(popped));
            popped++;
         end
         next_cycle();
      end
      chk("fill_pop_count", WIDTH'(popped), WIDTH'(64));

      // Streaming across pointer wrap
      do_reset();
      rd_prdy = 1'b1;
      pushed = 0; popped = 0; first = -1; last = -1; rd_wraps = 0; wr_wraps = 0;
      for (int k = 0; k < 400 && popped < 200; k++) begin
         wr_pvld = (pushed < 200);
         wr_pd   = WIDTH'(pushed + 1000);
         @(negedge clk);
         if (wr_pvld && wr_prdy) pushed++;
         if (ram_we && ram_wa == 6'd59) wr_wraps++;
         if (ram_re && ram_ra == 6'd59) rd_wraps++;
         if (rd_pvld) begin
            chk("wrap_data", rd_pd, WIDTH'(popped + 1000));
            if (first < 0) first = k;
            last = k;
            popped++;
         end
         next_cycle();
      end
      wr_pvld = 1'b0;
      chk("wrap_pushed", WIDTH'(pushed), WIDTH'(200));
      chk("wrap_popped", WIDTH'(popped), WIDTH'(200));
      chk("wrap_no_gaps", WIDTH'(last - first), WIDTH'(199));
      chk("wrap_first_pop", WIDTH'(first), WIDTH'(4));
      chk("wrap_wr_wraps", WIDTH'(wr_wraps), WIDTH'(3));
      chk("wrap_rd_wraps", WIDTH'(rd_wraps), WIDTH'(3));

      // Random valid/ready at 50%
      do_reset();
      hold = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         if (!hold) begin
            wr_pvld = 1'($urandom_range(0, 1));
            wr_pd   = rand_word();
         end
         rd_prdy = 1'($urandom_range(0, 1));
         @(negedge clk);
         hold = wr_pvld && !wr_prdy;
         next_cycle();
      end
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      repeat (80) next_cycle();

      // Reset with stored data and a read in flight
      do_reset();
      rd_prdy = 1'b0;
      for (int k = 0; k < 30; k++) begin
         wr_pvld = 1'b1;
         wr_pd   = WIDTH'(k + 500);
         next_cycle();
      end
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      next_cycle();
      rd_prdy = 1'b0;
      reset_  = 1'b0;
      next_cycle();
      reset_ = 1'b1;
      @(negedge clk);
      chk("rst_mid_rd_pvld", WIDTH'(rd_pvld), WIDTH'(0));
      chk("rst_mid_wr_prdy", WIDTH'(wr_prdy), WIDTH'(1));
      chk("rst_mid_ram_re", WIDTH'(ram_re), WIDTH'(0));
      chk("rst_mid_ram_ore", WIDTH'(ram_ore), WIDTH'(0));
      next_cycle();
      latency_test(WIDTH'(1), "rst_lat");

      // Push and issue in the same cycle with one entry stored
      do_reset();
      rd_prdy = 1'b1;
      wr_pvld = 1'b1;
      wr_pd   = WIDTH'(77);
      @(negedge clk);
      chk("sim_t0_we", WIDTH'(ram_we), WIDTH'(1));
      chk("sim_t0_re", WIDTH'(ram_re), WIDTH'(0));
      next_cycle();
      wr_pd = WIDTH'(78);
      @(negedge clk);
      chk("sim_t1_we", WIDTH'(ram_we), WIDTH'(1));
      chk("sim_t1_wa", WIDTH'(ram_wa), WIDTH'(1));
      chk("sim_t1_re", WIDTH'(ram_re), WIDTH'(1));
      chk("sim_t1_ra", WIDTH'(ram_ra), WIDTH'(0));
      next_cycle();
      wr_pvld = 1'b0;
      @(negedge clk);
      chk("sim_t2_re", WIDTH'(ram_re), WIDTH'(1));
      chk("sim_t2_ra", WIDTH'(ram_ra), WIDTH'(1));
      next_cycle();
      @(negedge clk);
      chk("sim_t3_re", WIDTH'(ram_re), WIDTH'(0));
      next_cycle();
      repeat (10) next_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
